// File: rtl/fetch_pc_controller.sv
// fetch_pc_controller
// PC sequencer for a two-wide fetch stage. It applies static backward-taken /
// forward-not-taken prediction to the bundle at pc and registers that bundle
// into the IF/ID register. It also handles decode stalls and execute-stage
// redirects, and inserts FLUSH_CYCLES bubbles after each redirect.

module fetch_pc_controller #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic [1:0]       branch_en,
  input  logic [1:0][31:0] imm,
  output logic [31:0]      pc,
  output logic [1:0]       fd_valid,
  output logic [31:0]      fd_pc,
  output logic [1:0]       fd_pred_taken,
  output logic [31:0]      fd_pred_target
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [3:0] FLUSH_INIT_C = 4'(FLUSH_CYCLES);

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  flush_cnt_r;
  logic [3:0]  flush_cnt_next_s;

  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic [1:0]  fd_valid_r;
  logic [1:0]  fd_valid_next_s;
  logic [31:0] fd_pc_r;
  logic [31:0] fd_pc_next_s;
  logic [1:0]  fd_pred_taken_r;
  logic [1:0]  fd_pred_taken_next_s;
  logic [31:0] fd_pred_target_r;
  logic [31:0] fd_pred_target_next_s;

  logic        taken0_s;
  logic        taken1_s;
  logic        s1_valid_s;
  logic [31:0] target_s;
  logic [31:0] seq_next_s;

  // Prediction: a slot is taken when its branch points backward; slot 0 shadows slot 1.
  always_comb begin
    taken0_s   = branch_en[0] & imm[0][31];
    taken1_s   = 1'b0;
    s1_valid_s = 1'b1;
    target_s   = 32'h0000_0000;
    seq_next_s = pc_r + 32'd8;
    if (taken0_s) begin
      s1_valid_s = 1'b0;
      target_s   = pc_r + imm[0];
      seq_next_s = target_s;
    end else if (branch_en[1] & imm[1][31]) begin
      taken1_s   = 1'b1;
      target_s   = pc_r + 32'd4 + imm[1];
      seq_next_s = target_s;
    end else begin
      taken1_s   = 1'b0;
    end
  end

  // Control state register: RUN/FLUSH and the bubble counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      flush_cnt_r <= 4'd0;
    end else begin
      state_r     <= state_next_s;
      flush_cnt_r <= flush_cnt_next_s;
    end
  end

  // Next-state logic: a redirect restarts the bubble count from any state.
  always_comb begin
    state_next_s     = state_r;
    flush_cnt_next_s = flush_cnt_r;
    if (redirect_valid) begin
      if (FLUSH_INIT_C != 4'd0) begin
        state_next_s     = ST_FLUSH;
        flush_cnt_next_s = FLUSH_INIT_C;
      end else begin
        state_next_s     = ST_RUN;
        flush_cnt_next_s = 4'd0;
      end
    end else begin
      case (state_r)
        ST_RUN: begin
          state_next_s     = ST_RUN;
          flush_cnt_next_s = 4'd0;
        end
        ST_FLUSH: begin
          // A count of 0 is unreachable in FLUSH. It is treated like the last bubble so that the FSM cannot stick.
          if (flush_cnt_r <= 4'd1) begin
            state_next_s     = ST_RUN;
            flush_cnt_next_s = 4'd0;
          end else begin
            state_next_s     = ST_FLUSH;
            flush_cnt_next_s = flush_cnt_r - 4'd1;
          end
        end
        default: begin
          state_next_s     = ST_RUN;
          flush_cnt_next_s = 4'd0;
        end
      endcase
    end
  end

  // Datapath next values: the fetch PC and the IF/ID register contents.
  always_comb begin
    pc_next_s             = pc_r;
    fd_valid_next_s       = fd_valid_r;
    fd_pc_next_s          = fd_pc_r;
    fd_pred_taken_next_s  = fd_pred_taken_r;
    fd_pred_target_next_s = fd_pred_target_r;
    if (redirect_valid) begin
      // A redirect drops any bundle held by a stall. The two low bits are forced to 0 so that pc stays word-aligned.
      pc_next_s            = {redirect_pc[31:2], 2'b00};
      fd_valid_next_s      = 2'b00;
      fd_pred_taken_next_s = 2'b00;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (!stall) begin
            pc_next_s             = seq_next_s;
            fd_valid_next_s       = {s1_valid_s, 1'b1};
            fd_pc_next_s          = pc_r;
            fd_pred_taken_next_s  = {taken1_s, taken0_s};
            fd_pred_target_next_s = target_s;
          end else begin
            pc_next_s             = pc_r;
          end
        end
        ST_FLUSH: begin
          fd_valid_next_s = 2'b00;
        end
        default: begin
          fd_valid_next_s = 2'b00;
        end
      endcase
    end
  end

  // Datapath registers: pc and the IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r             <= RESET_PC;
      fd_valid_r       <= 2'b00;
      fd_pc_r          <= 32'h0000_0000;
      fd_pred_taken_r  <= 2'b00;
      fd_pred_target_r <= 32'h0000_0000;
    end else begin
      pc_r             <= pc_next_s;
      fd_valid_r       <= fd_valid_next_s;
      fd_pc_r          <= fd_pc_next_s;
      fd_pred_taken_r  <= fd_pred_taken_next_s;
      fd_pred_target_r <= fd_pred_target_next_s;
    end
  end

  assign pc             = pc_r;
  assign fd_valid       = fd_valid_r;
  assign fd_pc          = fd_pc_r;
  assign fd_pred_taken  = fd_pred_taken_r;
  assign fd_pred_target = fd_pred_target_r;

endmodule

// File: tb/tb_fetch_pc_controller.sv
// Self-checking bench for fetch_pc_controller. It runs directed scenarios
// followed by a randomized run. The directed scenarios check against constants.
// The randomized run checks against a cycle-level behavioural model.

module tb_fetch_pc_controller;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          FLUSH  = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [1:0]       branch_en;
  logic [1:0][31:0] imm;
  logic [31:0]      pc;
  logic [1:0]       fd_valid;
  logic [31:0]      fd_pc;
  logic [1:0]       fd_pred_taken;
  logic [31:0]      fd_pred_target;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [1:0]  m_fdv;
  logic [31:0] m_fdpc;
  logic [1:0]  m_fdt;
  logic [31:0] m_tgt;
  int          m_flush_left;

  fetch_pc_controller #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .branch_en(branch_en), .imm(imm),
    .pc(pc), .fd_valid(fd_valid), .fd_pc(fd_pc),
    .fd_pred_taken(fd_pred_taken), .fd_pred_target(fd_pred_target)
  );

  always #5 clk = ~clk;

  // Apply one rising edge of behaviour to the model, using the current inputs.
  task automatic model_step();
    logic t0, t1;
    logic [31:0] nxt;
    if (rst) begin
      m_pc = RST_PC; m_fdv = 2'b00; m_fdpc = 32'd0; m_fdt = 2'b00; m_tgt = 32'd0;
      m_flush_left = 0;
    end else if (redirect_valid) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      m_fdv = 2'b00; m_fdt = 2'b00;
      m_flush_left = FLUSH;
    end else if (m_flush_left > 0) begin
      m_fdv = 2'b00;
      m_flush_left = m_flush_left - 1;
    end else if (!stall) begin
      t0 = branch_en[0] && imm[0][31];
      t1 = !t0 && branch_en[1] && imm[1][31];
      m_fdpc = m_pc;
      if (t0) begin
        m_fdv = 2'b01; m_fdt = 2'b01; m_tgt = m_pc + imm[0]; nxt = m_tgt;
      end else if (t1) begin
        m_fdv = 2'b11; m_fdt = 2'b10; m_tgt = m_pc + 32'd4 + imm[1]; nxt = m_tgt;
      end else begin
        m_fdv = 2'b11; m_fdt = 2'b00; m_tgt = 32'd0; nxt = m_pc + 32'd8;
      end
      m_pc = nxt;
    end
  endtask

  // One clock: drive at negedge, update the model at posedge, and return at the next negedge.
  task automatic cyc(input logic r, input logic st, input logic rv, input logic [31:0] rp,
                     input logic [1:0] be, input logic [31:0] i0, input logic [31:0] i1);
    rst = r; stall = st; redirect_valid = rv; redirect_pc = rp;
    branch_en = be; imm[0] = i0; imm[1] = i1;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 32'd0, 32'd0);
  endtask

  // Redirect and wait out the bubble so that pc == addr in RUN.
  task automatic go_to(input logic [31:0] addr);
    cyc(1'b0, 1'b0, 1'b1, addr, 2'b00, 32'd0, 32'd0);
    for (int i = 0; i < FLUSH; i++) idle();
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 32'd0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 32'd0, 32'd0);
    checks++;
    if ({pc, fd_valid, fd_pc, fd_pred_taken, fd_pred_target} !== {RST_PC, 2'b00, 32'd0, 2'b00, 32'd0}) begin
      errors++;
      $display("FAIL reset_state: got pc=%h v=%b fdpc=%h t=%b tgt=%h, expected all zero", pc, fd_valid, fd_pc, fd_pred_taken, fd_pred_target);
    end
    for (int k = 0; k < 3; k++) begin
      idle();
      checks++;
      if ({fd_pc, fd_valid, fd_pred_taken} !== {32'(k * 8), 2'b11, 2'b00}) begin
        errors++;
        $display("FAIL seq_%0d: got fd_pc=%h v=%b t=%b, expected fd_pc=%h v=11 t=00", k, fd_pc, fd_valid, fd_pred_taken, 32'(k * 8));
      end
    end
  endtask

  task automatic test_slot0_taken();
    go_to(32'h20);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 2'b01, 32'hFFFF_FFF0, 32'd0);
    checks++;
    if ({fd_pc, fd_valid, fd_pred_taken, fd_pred_target, pc} !== {32'h20, 2'b01, 2'b01, 32'h10, 32'h10}) begin
      errors++;
      $display("FAIL slot0_taken: got fd_pc=%h v=%b t=%b tgt=%h pc=%h, expected 20/01/01/10/10", fd_pc, fd_valid, fd_pred_taken, fd_pred_target, pc);
    end
    idle();
    checks++;
    if (fd_pc !== 32'h10) begin
      errors++;
      $display("FAIL slot0_next: got fd_pc=%h, expected 00000010", fd_pc);
    end
  endtask

  task automatic test_slot1();
    go_to(32'h40);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 2'b10, 32'd0, 32'h0000_000C);
    checks++;
    if ({fd_valid, fd_pred_taken, fd_pred_target} !== {2'b11, 2'b00, 32'd0}) begin
      errors++;
      $display("FAIL slot1_fwd: got v=%b t=%b tgt=%h, expected 11/00/0", fd_valid, fd_pred_taken, fd_pred_target);
    end
    idle();
    checks++;
    if (fd_pc !== 32'h48) begin
      errors++;
      $display("FAIL slot1_fwd_next: got fd_pc=%h, expected 00000048", fd_pc);
    end
    go_to(32'h40);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 2'b10, 32'd0, 32'hFFFF_FFF8);
    checks++;
    if ({fd_valid, fd_pred_taken, fd_pred_target, pc} !== {2'b11, 2'b10, 32'h3C, 32'h3C}) begin
      errors++;
      $display("FAIL slot1_bwd: got v=%b t=%b tgt=%h pc=%h, expected 11/10/3c/3c", fd_valid, fd_pred_taken, fd_pred_target, pc);
    end
    go_to(32'h40);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 2'b11, 32'hFFFF_FFF0, 32'hFFFF_FFF8);
    checks++;
    if ({fd_valid, fd_pred_taken, fd_pred_target, pc} !== {2'b01, 2'b01, 32'h30, 32'h30}) begin
      errors++;
      $display("FAIL both_bwd: got v=%b t=%b tgt=%h pc=%h, expected 01/01/30/30", fd_valid, fd_pred_taken, fd_pred_target, pc);
    end
  endtask

  task automatic test_stall();
    go_to(32'h8);
    idle();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'd0, 2'b01, 32'hFFFF_FF00, 32'd0);
      checks++;
      if ({fd_pc, fd_valid, pc} !== {32'h8, 2'b11, 32'h10}) begin
        errors++;
        $display("FAIL stall_hold_%0d: got fd_pc=%h v=%b pc=%h, expected 8/11/10", k, fd_pc, fd_valid, pc);
      end
    end
    idle();
    checks++;
    if ({fd_pc, fd_valid} !== {32'h10, 2'b11}) begin
      errors++;
      $display("FAIL stall_release: got fd_pc=%h v=%b, expected 10/11", fd_pc, fd_valid);
    end
  endtask

  task automatic test_redirect_flush();
    cyc(1'b0, 1'b1, 1'b1, 32'h103, 2'b00, 32'd0, 32'd0);
    checks++;
    if ({fd_valid, fd_pred_taken, pc} !== {2'b00, 2'b00, 32'h100}) begin
      errors++;
      $display("FAIL redir_r1: got v=%b t=%b pc=%h, expected 00/00/100", fd_valid, fd_pred_taken, pc);
    end
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 2'b00, 32'd0, 32'd0);
    checks++;
    if ({fd_valid, pc} !== {2'b00, 32'h100}) begin
      errors++;
      $display("FAIL redir_r2: got v=%b pc=%h, expected 00/100", fd_valid, pc);
    end
    idle();
    checks++;
    if ({fd_pc, fd_valid} !== {32'h100, 2'b11}) begin
      errors++;
      $display("FAIL redir_resume: got fd_pc=%h v=%b, expected 100/11", fd_pc, fd_valid);
    end
    cyc(1'b0, 1'b0, 1'b1, 32'h300, 2'b00, 32'd0, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 32'h200, 2'b00, 32'd0, 32'd0);
    idle();
    checks++;
    if ({fd_valid, pc} !== {2'b00, 32'h200}) begin
      errors++;
      $display("FAIL redir_restart: got v=%b pc=%h, expected 00/200", fd_valid, pc);
    end
    idle();
    checks++;
    if ({fd_pc, fd_valid} !== {32'h200, 2'b11}) begin
      errors++;
      $display("FAIL redir_restart_resume: got fd_pc=%h v=%b, expected 200/11", fd_pc, fd_valid);
    end
  endtask

  task automatic test_wrap_and_rst();
    go_to(32'hFFFF_FFF8);
    idle();
    idle();
    checks++;
    if ({fd_pc, fd_valid} !== {32'h0, 2'b11}) begin
      errors++;
      $display("FAIL wrap: got fd_pc=%h v=%b, expected 0/11", fd_pc, fd_valid);
    end
    cyc(1'b0, 1'b0, 1'b1, 32'h500, 2'b00, 32'd0, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 32'h600, 2'b00, 32'd0, 32'd0);
    checks++;
    if ({pc, fd_valid, fd_pc, fd_pred_taken} !== {RST_PC, 2'b00, 32'd0, 2'b00}) begin
      errors++;
      $display("FAIL rst_mid_flush: got pc=%h v=%b fd_pc=%h t=%b, expected reset values", pc, fd_valid, fd_pc, fd_pred_taken);
    end
    idle();
    checks++;
    if ({fd_pc, fd_valid} !== {RST_PC, 2'b11}) begin
      errors++;
      $display("FAIL rst_resume: got fd_pc=%h v=%b, expected %h/11", fd_pc, fd_valid, RST_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] i0, i1;
    for (int n = 0; n < 400; n++) begin
      i0 = $urandom; i1 = $urandom;
      if ($urandom_range(1, 0) == 0) i0[31] = 1'b0;
      if ($urandom_range(1, 0) == 0) i1[31] = 1'b0;
      cyc(($urandom_range(99, 0) < 2), ($urandom_range(3, 0) == 0), ($urandom_range(9, 0) == 0),
          $urandom, 2'($urandom_range(3, 0)), i0, i1);
      checks++;
      if ({pc, fd_valid, fd_pc, fd_pred_taken, fd_pred_target} !== {m_pc, m_fdv, m_fdpc, m_fdt, m_tgt}) begin
        errors++;
        $display("FAIL random_%0d: got pc=%h v=%b fdpc=%h t=%b tgt=%h, expected pc=%h v=%b fdpc=%h t=%b tgt=%h",
                 n, pc, fd_valid, fd_pc, fd_pred_taken, fd_pred_target, m_pc, m_fdv, m_fdpc, m_fdt, m_tgt);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    branch_en = 2'b00; imm[0] = 32'd0; imm[1] = 32'd0;
    m_pc = RST_PC; m_fdv = 2'b00; m_fdpc = 32'd0; m_fdt = 2'b00; m_tgt = 32'd0; m_flush_left = 0;
    @(negedge clk);
    test_reset();
    test_slot0_taken();
    test_slot1();
    test_stall();
    test_redirect_flush();
    test_wrap_and_rst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_controller.md
# fetch_pc_controller

Sequences the PC of the two-wide fetch stage and owns the IF/ID pipeline-register control. Each cycle it presents a bundle address, takes the per-slot branch flags and B-type immediates that the fetch decoder produces for that bundle, and applies static backward-taken/forward-not-taken (BTFN) prediction. It registers the bundle into decode with per-slot valid and prediction flags, and chooses the next PC. It also handles decode back-pressure and execute-stage redirects, inserting a programmable number of flush bubbles after each redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- FLUSH_CYCLES, 1, bubble cycles after a redirect before fetch resumes (0–15)
- clk  in  1  clock; one clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  decode did not consume the fd_* bundle this cycle
- redirect_valid  in  1  execute-stage PC correction
- redirect_pc  in  32  corrected PC
- branch_en  in  2×1  per-slot branch flag for the bundle at pc (slot 0 = pc, slot 1 = pc+4)
- imm  in  2×32  per-slot sign-extended B-type immediate
- pc  out  32  current bundle address to instruction memory (combinational read)
- fd_valid  out  2  registered per-slot valid to decode
- fd_pc  out  32  registered bundle address
- fd_pred_taken  out  2  registered per-slot predicted-taken flags
- fd_pred_target  out  32  registered target of the predicted-taken slot, 0 if none

## Operation
- States: RUN and FLUSH. flush_cnt is 4 bits.
- Prediction (combinational from branch_en/imm):
  - A slot predicts taken when branch_en=1 and imm[31]=1 (backward).
  - If slot 0 is taken: slot 1 is invalid, target = pc+imm[0], next = target.
  - Else if slot 1 is taken: slot 1 is valid, target = pc+4+imm[1], next = target.
  - Else: next = pc+8, target = 0.
  - Slot-1 branch_en is ignored when slot 0 is taken.
- All additions are 32-bit modulo 2^32, so wrap-around is silent.
- RUN, no stall, no redirect: fd_pc<=pc, fd_valid<={s1_valid,1}, fd_pred_taken/target<=prediction, pc<=next.
- RUN with stall=1 and no redirect: pc and all fd_* outputs hold.
- Redirect (any state, overrides stall):
  - pc<=redirect_pc with bits [1:0] forced to 0.
  - fd_valid<=0 and fd_pred_taken<=0.
  - If FLUSH_CYCLES>0: go to FLUSH with flush_cnt<=FLUSH_CYCLES. Else stay in RUN.
- FLUSH:
  - fd_valid<=0 and pc holds.
  - flush_cnt decrements; stall is ignored.
  - When flush_cnt=1, go to RUN.
  - A redirect during FLUSH reloads pc and flush_cnt.
- Reset: pc=RESET_PC, state=RUN, flush_cnt=0, fd_valid=0, fd_pc=0, fd_pred_taken=0, fd_pred_target=0.

## Timing
- pc is a register output. Instruction memory and the fetch decoder are combinational within the same cycle.
- Bundle latency: the bundle at pc in cycle N appears on fd_* in cycle N+1.
- First cycle after rst deasserts: fd_valid=0, pc=RESET_PC. The bundle at RESET_PC appears one cycle later.
- Redirect asserted in cycle R, with FLUSH_CYCLES=F:
  - fd_valid=0 in cycles R+1 … R+1+F.
  - fd_pc=redirect_pc with valid in cycle R+2+F.
- Stall asserted in cycle N: fd_* in cycle N+1 equal fd_* in cycle N.
- Redirect together with stall: redirect wins and the held bundle is dropped.
- rst in any state (including mid-FLUSH): all state returns to reset values next cycle. rst overrides redirect.

## Test plan
- Reset, RESET_PC=0, branch_en=00 always, no stall: fd_pc sequence 0x0,0x8,0x10 with fd_valid=11, fd_pred_taken=00; first post-reset cycle has fd_valid=00.
- pc=0x20, branch_en[0]=1, imm[0]=0xFFFFFFF0: fd_valid=01, fd_pred_taken=01, fd_pred_target=0x10; the next fd_pc=0x10.
- pc=0x40, branch_en=10:
  - imm[1]=0x0C (forward): fd_valid=11, fd_pred_taken=00, next fd_pc=0x48.
  - imm[1]=0xFFFFFFF8 (backward): fd_valid=11, fd_pred_taken=10, fd_pred_target=0x3C.
  - Both slots backward: slot 0 wins.
- fd_pc=0x8 with stall held 3 cycles: fd_* and pc are frozen; after release, fd_pc advances to the pc held during the stall.
- FLUSH_CYCLES=1, redirect_valid=1 with redirect_pc=0x103 while stall=1:
  - fd_valid=00 for 2 cycles, then fd_pc=0x100 with fd_valid=11.
  - A second redirect to 0x200 during FLUSH restarts the bubble count.
- pc=0xFFFFFFF8 with no branches: next fd_pc=0x0 (wrap). Asserting rst mid-FLUSH returns pc=RESET_PC with fd_valid=00.
